lsu_mem_share_ctrl: RTL and testbench

Shares one LSU memory request/response port between NUM_REQS requesters, for example the LSU and the SFU/ray unit, inside the execute stage. It does round-robin arbitration and gates each requester by a per-requester outstanding-read credit. It appends the requester index to the tag and routes responses back by that index. Output requests pass through a one-entry elastic register stage.

---
 rtl/lsu_share_pkg.sv | 30 +++
 rtl/lsu_mem_share_ctrl_if.sv | 26 ++
 rtl/lsu_rr_grant.sv | 41 ++++
 rtl/lsu_mem_share_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_share_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_share_pkg.sv
// Shared widths, helper functions and the request payload layout for the
// LSU memory-port sharing controller.
package lsu_share_pkg;

  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_DATA_SIZE  = 4;
  localparam int DEF_ADDR_WIDTH = 30;

  function automatic int calc_payload_w(input int lanes, input int dsize, input int aw);
    return 1 + lanes + lanes * dsize + lanes * aw + lanes * dsize * 8;
  endfunction

  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_rsp_w(input int lanes, input int dsize);
    return lanes * dsize * 8 + lanes;
  endfunction

  // Payload layout for the default lane configuration; rw sits in the MSB.
  typedef struct packed {
    logic                                          rw;
    logic [DEF_NUM_LANES-1:0]                      mask;
    logic [DEF_NUM_LANES*DEF_DATA_SIZE-1:0]        byteen;
    logic [DEF_NUM_LANES*DEF_ADDR_WIDTH-1:0]       addr;
    logic [DEF_NUM_LANES*DEF_DATA_SIZE*8-1:0]      data;
  } lsu_payload_t;

endpackage

// File: rtl/lsu_mem_share_ctrl_if.sv
// Request/response bus bundle; COUNT>1 carries one packed slice per requester.
interface lsu_mem_share_ctrl_if #(
  parameter int COUNT     = 1,
  parameter int PAYLOAD_W = 1,
  parameter int TAG_W     = 1,
  parameter int RSP_W     = 1
);
  logic [COUNT-1:0]           req_valid;
  logic [COUNT*PAYLOAD_W-1:0] req_payload;
  logic [COUNT*TAG_W-1:0]     req_tag;
  logic [COUNT-1:0]           req_ready;
  logic [COUNT-1:0]           rsp_valid;
  logic [COUNT*RSP_W-1:0]     rsp_data;
  logic [COUNT*TAG_W-1:0]     rsp_tag;
  logic [COUNT-1:0]           rsp_ready;

  modport master (
    output req_valid, req_payload, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_payload, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/lsu_rr_grant.sv
// Round-robin grant: searches upward from the pointer with wrap; the pointer
// only moves past the winner when the grant is consumed (fire).
module lsu_rr_grant #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     valid,
  input  logic             fire,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!grant_any && valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      ptr <= '0;
    else if (fire && grant_any)
      ptr <= IDX_W'((int'(grant_idx) + 1) % N);
  end

endmodule

// File: rtl/lsu_mem_share_ctrl.sv
// Shares one LSU memory port between NUM_REQS requesters with per-requester
// read credits. Define LSU_SHARE_PERF_EN to add per-requester stall counters.
module lsu_mem_share_ctrl
  import lsu_share_pkg::*;
#(
  parameter int NUM_REQS        = 2,
  parameter int NUM_LANES       = 4,
  parameter int DATA_SIZE       = 4,
  parameter int ADDR_WIDTH      = 30,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  lsu_mem_share_ctrl_if.slave   req_bus,
  lsu_mem_share_ctrl_if.master  mem_bus,
  output logic                  idle
`ifdef LSU_SHARE_PERF_EN
  ,
  output logic [NUM_REQS*32-1:0] perf_stall_cycles
`endif
);

  localparam int PAYLOAD_W = calc_payload_w(NUM_LANES, DATA_SIZE, ADDR_WIDTH);
  localparam int IDX_W     = calc_idx_w(NUM_REQS);
  localparam int RSP_W     = calc_rsp_w(NUM_LANES, DATA_SIZE);
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OUT_TAG_W = TAG_WIDTH + IDX_W;

  logic [NUM_REQS-1:0]  eligible;
  logic [NUM_REQS-1:0]  is_write;
  logic [NUM_REQS-1:0]  grant;
  logic [NUM_REQS-1:0]  req_ready_v;
  logic [NUM_REQS-1:0]  rd_accept;
  logic [NUM_REQS-1:0]  rsp_valid_v;
  logic [NUM_REQS-1:0]  rsp_fire;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 can_load;
  logic                 fire;

  logic [CNT_W-1:0]     cnt [NUM_REQS];
  logic                 any_busy;

  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [OUT_TAG_W-1:0] out_tag;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [TAG_WIDTH-1:0] sel_tag;

  logic [IDX_W-1:0]     rsp_idx;
  logic                 rsp_idx_ok;
  logic                 sel_rsp_ready;
  logic                 rsp_underflow;

  always_comb begin
    is_write = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      is_write[i] = req_bus.req_payload[i*PAYLOAD_W + PAYLOAD_W - 1];
      eligible[i] = req_bus.req_valid[i] &&
                    (is_write[i] || (cnt[i] < CNT_W'(MAX_OUTSTANDING)));
    end
  end

  lsu_rr_grant #(
    .N     (NUM_REQS),
    .IDX_W (IDX_W)
  ) u_grant (
    .clk       (clk),
    .reset     (reset),
    .valid     (eligible),
    .fire      (fire),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Nothing is accepted while reset is held, so the slot cannot fill then.
  assign can_load    = !out_valid || mem_bus.req_ready[0];
  assign fire        = grant_any && can_load && reset;
  assign req_ready_v = grant & {NUM_REQS{can_load && reset}};
  assign rd_accept   = req_ready_v & ~is_write;
  assign req_bus.req_ready = req_ready_v;

  always_comb begin
    sel_payload = '0;
    sel_tag     = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        sel_payload = req_bus.req_payload[i*PAYLOAD_W +: PAYLOAD_W];
        sel_tag     = req_bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      out_valid <= 1'b0;
    else if (fire)
      out_valid <= 1'b1;
    else if (mem_bus.req_ready[0])
      out_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      out_payload <= sel_payload;
      out_tag     <= {grant_idx, sel_tag};
    end
  end

  assign mem_bus.req_valid   = out_valid;
  assign mem_bus.req_payload = out_payload;
  assign mem_bus.req_tag     = out_tag;

  // Out-of-range indices are swallowed (ready=1) so a bad tag cannot wedge the port.
  assign rsp_idx = mem_bus.rsp_tag[OUT_TAG_W-1 -: IDX_W];

  always_comb begin
    rsp_idx_ok    = 1'b0;
    sel_rsp_ready = 1'b1;
    rsp_underflow = 1'b0;
    rsp_valid_v   = '0;
    rsp_fire      = '0;
    for (int j = 0; j < NUM_REQS; j++) begin
      if (rsp_idx == IDX_W'(j)) begin
        rsp_idx_ok     = 1'b1;
        sel_rsp_ready  = req_bus.rsp_ready[j];
        rsp_underflow  = (cnt[j] == '0);
        rsp_valid_v[j] = reset && mem_bus.rsp_valid[0];
        rsp_fire[j]    = reset && mem_bus.rsp_valid[0] && req_bus.rsp_ready[j];
      end
    end
  end

  assign mem_bus.rsp_ready = sel_rsp_ready;
  assign req_bus.rsp_valid = rsp_valid_v;
  assign req_bus.rsp_data  = {NUM_REQS{mem_bus.rsp_data[RSP_W-1:0]}};
  assign req_bus.rsp_tag   = {NUM_REQS{mem_bus.rsp_tag[TAG_WIDTH-1:0]}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (rd_accept[i] && !rsp_fire[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!rd_accept[i] && rsp_fire[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < NUM_REQS; i++)
      any_busy = any_busy || (cnt[i] != '0);
  end

  assign idle = !any_busy && !out_valid;

`ifdef LSU_SHARE_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_bus.req_valid[i] && !req_ready_v[i])
          perf_stall_cycles[i*32 +: 32] <= perf_stall_cycles[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

  a_rsp_idx_range: assert property (@(posedge clk) disable iff (!reset)
    !(mem_bus.rsp_valid[0] && !rsp_idx_ok));

  a_rsp_no_credit: assert property (@(posedge clk) disable iff (!reset)
    !(mem_bus.rsp_valid[0] && sel_rsp_ready && rsp_idx_ok && rsp_underflow));

endmodule

// File: tb/tb_lsu_mem_share_ctrl.sv
// Directed self-checking bench for lsu_mem_share_ctrl (two requesters,
// default lane configuration).
module tb_lsu_mem_share_ctrl;
  import lsu_share_pkg::*;

  localparam int NUM_REQS  = 2;
  localparam int TAG_WIDTH = 8;
  localparam int IDX_W     = 1;
  localparam int PAYLOAD_W = calc_payload_w(4, 4, 30);
  localparam int RSP_W     = calc_rsp_w(4, 4);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic idle;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_mem_share_ctrl_if #(.COUNT(NUM_REQS), .PAYLOAD_W(PAYLOAD_W),
                          .TAG_W(TAG_WIDTH), .RSP_W(RSP_W)) req_bus();
  lsu_mem_share_ctrl_if #(.COUNT(1), .PAYLOAD_W(PAYLOAD_W),
                          .TAG_W(TAG_WIDTH + IDX_W), .RSP_W(RSP_W)) mem_bus();

`ifdef LSU_SHARE_PERF_EN
  logic [NUM_REQS*32-1:0] perf_stall_cycles;
`endif

  lsu_mem_share_ctrl #(
    .NUM_REQS        (NUM_REQS),
    .NUM_LANES       (4),
    .DATA_SIZE       (4),
    .ADDR_WIDTH      (30),
    .TAG_WIDTH       (TAG_WIDTH),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_bus (req_bus),
    .mem_bus (mem_bus),
    .idle    (idle)
`ifdef LSU_SHARE_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  function automatic logic [PAYLOAD_W-1:0] make_payload(input logic rw, input logic [7:0] seed);
    lsu_payload_t p;
    p.rw     = rw;
    p.mask   = 4'hF;
    p.byteen = 16'hFFFF;
    p.addr   = {4{22'd0, seed}};
    p.data   = {4{24'hC0FFEE, seed}};
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [299:0] actual, input logic [299:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic rw0, input logic [7:0] tag0,
                               input logic rw1, input logic [7:0] tag1, input logic out_ready);
    req_bus.req_valid   = valid;
    req_bus.req_payload = {make_payload(rw1, tag1), make_payload(rw0, tag0)};
    req_bus.req_tag     = {tag1, tag0};
    mem_bus.req_ready   = out_ready;
  endtask

  task automatic applyResponse(input logic valid, input logic [8:0] tag, input logic [1:0] ready);
    mem_bus.rsp_valid = valid;
    mem_bus.rsp_tag   = tag;
    mem_bus.rsp_data  = {4'hA, {4{8'h00, tag[7:0], 16'hBEEF}}};
    req_bus.rsp_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    applyStimulus(2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    applyResponse(1'b0, 9'h000, 2'b00);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset holds everything quiet even with live inputs
    reset = 1'b0;
    applyStimulus(2'b11, 1'b0, 8'h10, 1'b0, 8'h20, 1'b1);
    applyResponse(1'b1, 9'h010, 2'b11);
    tick();
    tick();
    checkOutput("rst_out_valid", 300'(mem_bus.req_valid), 300'(1'b0));
    checkOutput("rst_idle",      300'(idle),              300'(1'b1));
    checkOutput("rst_req_ready", 300'(req_bus.req_ready), 300'(2'b00));
    checkOutput("rst_rsp_valid", 300'(req_bus.rsp_valid), 300'(2'b00));
    applyResponse(1'b0, 9'h000, 2'b00);
    reset = 1'b1;

    // Alternating grants at one request per cycle
    #1;
    checkOutput("rr_first_ready", 300'(req_bus.req_ready), 300'(2'b01));
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rr_valid", 300'(mem_bus.req_valid), 300'(1'b1));
      checkOutput("rr_tag", 300'(mem_bus.req_tag), (k % 2 == 0) ? 300'(9'h010) : 300'(9'h120));
      checkOutput("rr_payload", 300'(mem_bus.req_payload),
                  (k % 2 == 0) ? 300'(make_payload(1'b0, 8'h10)) : 300'(make_payload(1'b0, 8'h20)));
      checkOutput("rr_next_ready", 300'(req_bus.req_ready), (k % 2 == 0) ? 300'(2'b10) : 300'(2'b01));
    end
    applyStimulus(2'b00, 1'b0, 8'h10, 1'b0, 8'h20, 1'b1);
    tick();
    checkOutput("rr_drain_valid", 300'(mem_bus.req_valid), 300'(1'b0));
    checkOutput("rr_busy_idle",   300'(idle),              300'(1'b0));

    // Writes take no credit
    do_reset();
    applyStimulus(2'b01, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("wr_tag",     300'(mem_bus.req_tag),     300'(9'h055));
    checkOutput("wr_payload", 300'(mem_bus.req_payload), 300'(make_payload(1'b1, 8'h55)));
    applyStimulus(2'b00, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("wr_idle", 300'(idle), 300'(1'b1));

    // Credit exhaustion on requester 0
    do_reset();
    applyStimulus(2'b01, 1'b0, 8'h01, 1'b0, 8'h02, 1'b1);
    repeat (8) tick();
    #1;
    checkOutput("cr_full_ready", 300'(req_bus.req_ready), 300'(2'b00));
    applyStimulus(2'b11, 1'b0, 8'h01, 1'b0, 8'h02, 1'b1);
    #1;
    checkOutput("cr_other_ready", 300'(req_bus.req_ready), 300'(2'b10));
    tick();
    checkOutput("cr_other_tag", 300'(mem_bus.req_tag), 300'(9'h102));
    applyStimulus(2'b01, 1'b0, 8'h01, 1'b0, 8'h02, 1'b1);
    applyResponse(1'b1, 9'h001, 2'b01);
    #1;
    checkOutput("cr_rsp_valid",    300'(req_bus.rsp_valid), 300'(2'b01));
    checkOutput("cr_in_rsp_ready", 300'(mem_bus.rsp_ready), 300'(1'b1));
    checkOutput("cr_still_full",   300'(req_bus.req_ready), 300'(2'b00));
    tick();
    applyResponse(1'b0, 9'h000, 2'b00);
    #1;
    checkOutput("cr_freed_ready", 300'(req_bus.req_ready), 300'(2'b01));
    tick();
    checkOutput("cr_freed_tag", 300'(mem_bus.req_tag), 300'(9'h001));

    // Back-pressure holds the slot
    do_reset();
    applyStimulus(2'b01, 1'b0, 8'h33, 1'b0, 8'h44, 1'b1);
    tick();
    applyStimulus(2'b11, 1'b0, 8'h33, 1'b0, 8'h44, 1'b0);
    #1;
    checkOutput("bp_ready_low", 300'(req_bus.req_ready), 300'(2'b00));
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("bp_valid",   300'(mem_bus.req_valid),   300'(1'b1));
      checkOutput("bp_tag",     300'(mem_bus.req_tag),     300'(9'h033));
      checkOutput("bp_payload", 300'(mem_bus.req_payload), 300'(make_payload(1'b0, 8'h33)));
      checkOutput("bp_hold",    300'(req_bus.req_ready),   300'(2'b00));
    end
    applyStimulus(2'b11, 1'b0, 8'h33, 1'b0, 8'h44, 1'b1);
    #1;
    checkOutput("bp_release_ready", 300'(req_bus.req_ready), 300'(2'b10));
    tick();
    checkOutput("bp_next_tag",     300'(mem_bus.req_tag),     300'(9'h144));
    checkOutput("bp_next_payload", 300'(mem_bus.req_payload), 300'(make_payload(1'b0, 8'h44)));
    applyStimulus(2'b00, 1'b0, 8'h33, 1'b0, 8'h44, 1'b1);
    tick();
    checkOutput("bp_one_xfer", 300'(mem_bus.req_valid), 300'(1'b0));

    // Response routing with requester-side back-pressure
    do_reset();
    applyStimulus(2'b10, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1);
    tick();
    applyStimulus(2'b00, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1);
    tick();
    checkOutput("rt_busy", 300'(idle), 300'(1'b0));
    applyResponse(1'b1, 9'h13C, 2'b01);
    #1;
    checkOutput("rt_in_ready_low", 300'(mem_bus.rsp_ready), 300'(1'b0));
    checkOutput("rt_rsp_valid",    300'(req_bus.rsp_valid), 300'(2'b10));
    checkOutput("rt_rsp_tag",      300'(req_bus.rsp_tag),   300'(16'h3C3C));
    checkOutput("rt_rsp_data",     300'(req_bus.rsp_data[2*RSP_W-1 -: RSP_W]),
                300'({4'hA, {4{8'h00, 8'h3C, 16'hBEEF}}}));
    tick();
    checkOutput("rt_held_busy", 300'(idle), 300'(1'b0));
    applyResponse(1'b1, 9'h13C, 2'b10);
    #1;
    checkOutput("rt_in_ready_high", 300'(mem_bus.rsp_ready), 300'(1'b1));
    tick();
    applyResponse(1'b0, 9'h000, 2'b00);
    #1;
    checkOutput("rt_idle_after", 300'(idle), 300'(1'b1));

    // Same-cycle accept and response keep the credit count
    do_reset();
    applyStimulus(2'b01, 1'b0, 8'h66, 1'b0, 8'h00, 1'b1);
    tick();
    applyResponse(1'b1, 9'h066, 2'b01);
    tick();
    applyStimulus(2'b00, 1'b0, 8'h66, 1'b0, 8'h00, 1'b1);
    applyResponse(1'b0, 9'h000, 2'b00);
    tick();
    checkOutput("sim_cnt_kept", 300'(idle), 300'(1'b0));
    applyResponse(1'b1, 9'h066, 2'b01);
    tick();
    applyResponse(1'b0, 9'h000, 2'b00);
    #1;
    checkOutput("sim_idle", 300'(idle), 300'(1'b1));

    // Reset in the middle of traffic
    do_reset();
    applyStimulus(2'b01, 1'b0, 8'h77, 1'b0, 8'h88, 1'b1);
    repeat (3) tick();
    applyStimulus(2'b00, 1'b0, 8'h77, 1'b0, 8'h88, 1'b0);
    #1;
    checkOutput("mid_full",  300'(mem_bus.req_valid), 300'(1'b1));
    checkOutput("mid_busy",  300'(idle),              300'(1'b0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    applyStimulus(2'b11, 1'b0, 8'h77, 1'b0, 8'h88, 1'b1);
    #1;
    checkOutput("mid_valid_cleared", 300'(mem_bus.req_valid), 300'(1'b0));
    checkOutput("mid_idle",          300'(idle),              300'(1'b1));
    checkOutput("mid_grant_restart", 300'(req_bus.req_ready), 300'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
